// File: rtl/image_load_pkg.sv
// Purpose : shared types and defaults for the image load sequencer slice.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: FSM state enum, default word/frame sizes, words-per-frame helper.
package image_load_pkg;

   localparam int DEF_WORD_W     = 32;
   localparam int DEF_FRAME_BITS = 784;

   // Number of words needed to carry frameBits, rounding the last one up.
   function automatic int wordsPerFrame(input int frameBits, input int wordW);
      return (frameBits + wordW - 1) / wordW;
   endfunction

   localparam int WORDS_PER_FRAME = wordsPerFrame(DEF_FRAME_BITS, DEF_WORD_W);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      CAPTURE,
      PRESENT,
      WAIT_ACK_LOW
   } ilsState_t;

endpackage

// File: rtl/word_assembler.sv
// Purpose : packs serial bits LSB-first into a WORD_W register.
// Latency : bit lands in oWord on the edge that samples iWrEn.
// Backpressure: none; the caller only writes when it wants a bit stored.
// Ports   : iCLK/iRST (sync, active-low), iClr (sync clear of word and count),
//           iWrEn/iBit (write iBit at position oBitCnt), oWord, oBitCnt,
//           oWordFull (current write position is the top bit).
module word_assembler
   import image_load_pkg::*;
#(
   parameter  int WORD_W = DEF_WORD_W,
   localparam int CNT_W  = $clog2(WORD_W)
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iClr,
   input  logic              iWrEn,
   input  logic              iBit,
   output logic [WORD_W-1:0] oWord,
   output logic [CNT_W-1:0]  oBitCnt,
   output logic              oWordFull
);

   always_ff @(posedge iCLK) begin
      if (!iRST || iClr) begin
         oWord   <= '0;
         oBitCnt <= '0;
      end else if (iWrEn) begin
         oWord[oBitCnt] <= iBit;
         // Wraps to 0 after the top bit; the next word clears it anyway.
         oBitCnt        <= oBitCnt + CNT_W'(1);
      end
   end

   assign oWordFull = (oBitCnt == CNT_W'(WORD_W - 1));

endmodule

// File: rtl/image_load_sequencer.sv
// Purpose : requests one image's bits, packs them into words, hands words to
//           the HPS with a four-phase valid/ack handshake, pulses frame done.
// Latency : 2 cycles per bit; first oBitRd the cycle after start, oWordValid
//           2*WORD_W cycles after the first oBitRd.
// Backpressure: bit requests stop while a word waits for ack rise and fall.
// Ports   : iCLK, iRST (sync, active-low), iStart, iAbort, iBit/oBitRd (bit
//           source), oWord/oWordValid/iWordAck/oWordIdx (HPS side), oBusy,
//           oFrameDone.
module image_load_sequencer
   import image_load_pkg::*;
#(
   parameter int WORD_W     = DEF_WORD_W,
   parameter int FRAME_BITS = DEF_FRAME_BITS,
   parameter int IDX_W      = 5
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iStart,
   input  logic              iAbort,
   input  logic              iBit,
   output logic              oBitRd,
   output logic [WORD_W-1:0] oWord,
   output logic              oWordValid,
   input  logic              iWordAck,
   output logic [IDX_W-1:0]  oWordIdx,
   output logic              oBusy,
   output logic              oFrameDone
);

   localparam int CNT_W = $clog2(WORD_W);
   localparam int TOT_W = $clog2(FRAME_BITS + 1);

   ilsState_t        state;
   logic [TOT_W-1:0] total;
   logic [CNT_W-1:0] bitCnt;
   logic             wordFull;
   logic             asmClr;
   logic             asmWr;
   logic             startOk;
   logic             lastBit;
   logic             abortNow;

   // A start is only taken with the ack low, so a leftover ack from the HPS
   // cannot complete a handshake that never happened. Abort beats start.
   assign startOk  = iStart && !iWordAck && !iAbort;
   assign abortNow = iAbort && (state != IDLE);
   assign lastBit  = (total == TOT_W'(FRAME_BITS - 1));
   assign asmWr    = (state == CAPTURE) && !iAbort;

   // The word register is cleared at frame start, between words, and on abort.
   always_comb begin
      asmClr = 1'b0;
      case (state)
         IDLE:         asmClr = startOk;
         WAIT_ACK_LOW: asmClr = !iWordAck && (total != TOT_W'(FRAME_BITS));
         default:      asmClr = 1'b0;
      endcase
      if (abortNow) asmClr = 1'b1;
   end

   word_assembler #(
      .WORD_W (WORD_W)
   ) uAsm (
      .iCLK      (iCLK),
      .iRST      (iRST),
      .iClr      (asmClr),
      .iWrEn     (asmWr),
      .iBit      (iBit),
      .oWord     (oWord),
      .oBitCnt   (bitCnt),
      .oWordFull (wordFull)
   );

   always_ff @(posedge iCLK) begin
      if (!iRST) begin
         state      <= IDLE;
         total      <= '0;
         oWordIdx   <= '0;
         oBitRd     <= 1'b0;
         oWordValid <= 1'b0;
         oBusy      <= 1'b0;
         oFrameDone <= 1'b0;
      end else begin
         oBitRd     <= 1'b0;
         oFrameDone <= 1'b0;
         if (abortNow) begin
            state      <= IDLE;
            total      <= '0;
            oWordIdx   <= '0;
            oWordValid <= 1'b0;
            oBusy      <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (startOk) begin
                     state    <= REQ;
                     total    <= '0;
                     oWordIdx <= '0;
                     oBitRd   <= 1'b1;
                     oBusy    <= 1'b1;
                  end
               end
               REQ: begin
                  state <= CAPTURE;
               end
               CAPTURE: begin
                  total <= total + TOT_W'(1);
                  // The final word stops early; its upper bits stay cleared.
                  if (wordFull || lastBit) begin
                     state      <= PRESENT;
                     oWordValid <= 1'b1;
                  end else begin
                     state  <= REQ;
                     oBitRd <= 1'b1;
                  end
               end
               PRESENT: begin
                  if (iWordAck) begin
                     state      <= WAIT_ACK_LOW;
                     oWordValid <= 1'b0;
                  end
               end
               WAIT_ACK_LOW: begin
                  if (!iWordAck) begin
                     if (total == TOT_W'(FRAME_BITS)) begin
                        state      <= IDLE;
                        oBusy      <= 1'b0;
                        oFrameDone <= 1'b1;
                     end else begin
                        state    <= REQ;
                        oBitRd   <= 1'b1;
                        oWordIdx <= oWordIdx + IDX_W'(1);
                     end
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_image_load_sequencer.sv
// Purpose : directed self-checking bench for image_load_sequencer.
// Latency : n/a.
// Backpressure: the bench plays the HPS, acking 3 cycles after valid.
module tb_image_load_sequencer;

   logic        iCLK = 1'b0;
   logic        iRST = 1'b0;
   logic        iStart = 1'b0;
   logic        iAbort = 1'b0;
   logic        iBit = 1'b0;
   logic        iWordAck = 1'b0;
   logic        oBitRd;
   logic [31:0] oWord;
   logic        oWordValid;
   logic [4:0]  oWordIdx;
   logic        oBusy;
   logic        oFrameDone;

   int nAssert = 0;
   int nFail   = 0;
   int cyc     = 0;
   int bitIdx  = 0;
   int bitRdCnt = 0;
   int doneCnt = 0;
   bit bitPend = 0;

   image_load_sequencer dut (
      .iCLK       (iCLK),
      .iRST       (iRST),
      .iStart     (iStart),
      .iAbort     (iAbort),
      .iBit       (iBit),
      .oBitRd     (oBitRd),
      .oWord      (oWord),
      .oWordValid (oWordValid),
      .iWordAck   (iWordAck),
      .oWordIdx   (oWordIdx),
      .oBusy      (oBusy),
      .oFrameDone (oFrameDone)
   );

   always #5 iCLK = ~iCLK;

   function automatic logic pix(input int n);
      return (n % 3 == 0);
   endfunction

   function automatic logic [31:0] expWord(input int w);
      logic [31:0] r;
      r = '0;
      for (int b = 0; b < 32; b++) begin
         int n;
         n = w * 32 + b;
         r[b] = (n < 784) && (n % 3 == 0);
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAssert++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock; the bit source answers a request in the following cycle and
   // drives the inverse of the next bit otherwise, so early sampling shows up.
   task automatic tick();
      @(posedge iCLK);
      #1;
      if (bitPend) begin
         iBit = pix(bitIdx);
         bitIdx++;
         bitPend = 0;
      end else begin
         iBit = ~pix(bitIdx);
      end
      if (oBitRd) begin
         bitPend = 1;
         bitRdCnt++;
      end
      if (oFrameDone) doneCnt++;
      cyc++;
   endtask

   task automatic checkIdleOutputs(input string tag);
      check({tag, "_word"},  oWord, 32'h0);
      check({tag, "_idx"},   oWordIdx, 32'h0);
      check({tag, "_bitrd"}, oBitRd, 1'b0);
      check({tag, "_valid"}, oWordValid, 1'b0);
      check({tag, "_busy"},  oBusy, 1'b0);
      check({tag, "_done"},  oFrameDone, 1'b0);
   endtask

   // mode 0: full frame, 1: full frame with start pulsed in word 5,
   // 2: abort after 10 bits of word 3, 3: reset while word 2 is presented.
   task automatic runFrame(input int mode);
      int w;
      int guard;
      bit injected;
      bitIdx = 0; bitPend = 0; bitRdCnt = 0; doneCnt = 0;
      w = 0; guard = 0; injected = 0;
      cyc = 0;
      iStart = 1'b1;
      tick();
      iStart = 1'b0;
      check("first_bitrd", oBitRd, 1'b1);
      check("busy_high", oBusy, 1'b1);
      while (doneCnt == 0 && guard < 6000) begin
         if (oWordValid) begin
            if (mode == 3 && w == 2) begin
               iRST = 1'b0;
               tick();
               iRST = 1'b1;
               checkIdleOutputs("rst_present");
               iWordAck = 1'b1;
               repeat (3) tick();
               checkIdleOutputs("rst_ack");
               iWordAck = 1'b0;
               tick();
               return;
            end
            check("word_idx", oWordIdx, w);
            check("word_dat", oWord, expWord(w));
            if (w == 0) begin
               check("valid_cycle", cyc, 65);
               check("word0_const", oWord, 32'h49249249);
            end
            if (w == 24) check("word24_pad", oWord[31:16], 16'h0);
            repeat (3) tick();
            check("word_hold", oWord, expWord(w));
            check("valid_hold", oWordValid, 1'b1);
            iWordAck = 1'b1;
            tick();
            check("valid_drop", oWordValid, 1'b0);
            tick();
            iWordAck = 1'b0;
            w++;
         end else if (mode == 2 && bitIdx == 106) begin
            iAbort = 1'b1;
            tick();
            iAbort = 1'b0;
            checkIdleOutputs("abort");
            repeat (5) tick();
            check("abort_nodone", doneCnt, 0);
            check("abort_stays_idle", oBusy, 1'b0);
            return;
         end else begin
            iStart = (mode == 1) && !injected && (bitIdx == 163);
            if (iStart) injected = 1;
            tick();
            iStart = 1'b0;
         end
         guard++;
      end
      check("frame_in_time", guard < 6000, 1'b1);
      check("word_count", w, 25);
      check("bitrd_count", bitRdCnt, 784);
      check("done_count", doneCnt, 1);
      check("done_pulse_now", oFrameDone, 1'b1);
      check("busy_low_at_done", oBusy, 1'b0);
      tick();
      check("done_one_cycle", oFrameDone, 1'b0);
      repeat (5) tick();
      check("single_done", doneCnt, 1);
      check("idle_after_frame", oBusy, 1'b0);
   endtask

   initial begin
      iRST = 1'b0;
      repeat (2) tick();
      checkIdleOutputs("reset");
      iRST = 1'b1;
      tick();

      // Stale ack blocks a start.
      iWordAck = 1'b1;
      iStart   = 1'b1;
      tick();
      iStart = 1'b0;
      tick();
      check("stale_ack_busy", oBusy, 1'b0);
      check("stale_ack_bitrd", oBitRd, 1'b0);
      iWordAck = 1'b0;
      tick();

      // Abort together with start in IDLE: abort wins.
      iAbort = 1'b1;
      iStart = 1'b1;
      tick();
      iAbort = 1'b0;
      iStart = 1'b0;
      check("abort_start_busy", oBusy, 1'b0);
      tick();
      check("abort_start_bitrd", oBitRd, 1'b0);

      runFrame(0);
      runFrame(2);
      runFrame(1);
      runFrame(3);
      runFrame(0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
